led_multi_ctl: RTL and testbench
================================

Name: led_multi_ctl

Overview:
- Parametrised successor to the single free-running LED divider.
- Drives CH independent LED outputs from one 25 MHz clock.
- Each channel is configured through a simple write port for mode (off / on / blink / breathe), PWM brightness and blink/breathe rate.
- Sits between board-level LED pins and any control logic or test FSM that needs status indication.

Parameters:
- CH, 4: number of LED channels (1..16).
- TICK_DIV, 25000: clk cycles per time-base tick (25000 gives 1 ms at 25 MHz); must be >= 2.
- PWM_BITS, 8: PWM counter and duty width.
- PER_BITS, 10: blink/breathe interval width, in ticks.
- CH_W, 2: channel-select width; must be >= ceil(log2(CH)), min 1.

Ports:
- clk  in  1  system clock, 25 MHz nominal
- rst_n  in  1  asynchronous reset, active low
- cfg_we  in  1  config write strobe, one clk cycle
- cfg_ch  in  CH_W  target channel index
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BREATHE
- cfg_duty  in  PWM_BITS  brightness (PWM compare value)
- cfg_per  in  PER_BITS  blink half-period / breathe step interval, in ticks
- tick  out  1  time-base pulse, high for one clk every TICK_DIV cycles
- led  out  CH  LED drive, active high, registered

Behaviour:
- Reset (async assert, sync release):
  - led = 0, tick = 0.
  - All channels mode = OFF, duty = 0, per = 0.
  - Prescaler, PWM counter and all channel counters = 0; blink phase = 0; breathe ramp = 0, direction = up.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is registered, high on the cycle after the count equals TICK_DIV-1.
- PWM counter:
  - Shared, free-running, PWM_BITS wide, +1 every clk, wraps 2^PWM_BITS-1 -> 0.
  - pwm_on(d) = (pwm_cnt < d).
  - d = 0 is always off; d = all-ones gives (2^PWM_BITS-1)/2^PWM_BITS high.
- Config write:
  - On a cfg_we cycle with cfg_ch < CH, latch mode, duty and per into channel cfg_ch.
  - Also clear that channel's interval counter, set blink phase = 1, ramp = 0, direction = up.
  - cfg_ch >= CH: write ignored, no state change.
  - New config affects led on the next clk.
- Effective interval: per = 0 is treated as 1.
- Channel state update (evaluated each tick, skipped for a channel written in the same cycle):
  - Interval counter +1.
  - When it reaches the effective interval, it clears and fires a step event.
- Mode behaviour, led[i] registered from:
  - OFF: 0.
  - ON: pwm_on(duty).
  - BLINK: each step event toggles phase; led = phase & pwm_on(duty); full period = 2*per ticks.
  - BREATHE:
    - Each step event moves ramp by 1 toward duty when direction = up, toward 0 when down.
    - Reaching duty flips direction to down; reaching 0 flips it to up.
    - duty = 0 holds ramp at 0.
    - led = pwm_on(ramp).
    - If duty is rewritten below the current ramp, ramp restarts at 0 going up (this is part of the write clear).
- Latency:
  - led reflects the current counter state one clk later.
  - There is no combinational path from cfg_* to led.
- Channels are fully independent; simultaneous tick and write on different channels are both honoured.
- Reset mid-operation returns everything to the reset state immediately, regardless of clk.

Test Plan (TICK_DIV = 4, PWM_BITS = 4, PER_BITS = 4, CH = 4):
1. Reset, no writes, run 200 clk -> led = 0000 throughout; tick high exactly 1 of every 4 clk, first pulse on clk 4 after reset release.
2. Write ch0 ON duty = 8 -> led[0] high for 8 of every 16 clk, pattern steady; duty = 0 -> constantly 0; duty = 15 -> low exactly 1 of 16 clk.
3. Write ch1 BLINK duty = 15 per = 2 -> led[1] PWM-gated high for 8 clk (2 ticks), then low for 8 clk, repeating; per = 0 behaves as per = 1 (4-clk phases).
4. Write ch2 BREATHE duty = 3 per = 1 -> ramp sequence 0,1,2,3,2,1,0,1… advancing once per tick; PWM high count per 16 clk tracks the ramp.
5. Write cfg_ch = 5 (out of range) -> no channel changes. On the same cycle as a tick, write ch3 BLINK -> ch3 phase = 1 and counter = 0, with the tick not applied to ch3; other channels still advance.
6. Assert rst_n low mid-blink between clk edges -> led goes to 0000 immediately; after release all channels OFF until rewritten.

Source files
------------

// File: rtl/led_multi_ctl.sv
// Multi-channel LED controller: shared prescaler tick and PWM counter, per-channel
// OFF / ON / BLINK / BREATHE modes configured through a single write port.
module led_multi_ctl #(
    parameter int CH       = 4,
    parameter int TICK_DIV = 25000,
    parameter int PWM_BITS = 8,
    parameter int PER_BITS = 10,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic [PER_BITS-1:0] cfg_per,
    output logic                tick,
    output logic [CH-1:0]       led
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    logic [PRE_W-1:0]    presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [CH-1:0]       led_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            tick    <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            tick    <= (presc == PRE_W'(TICK_DIV - 1));
            presc   <= (presc == PRE_W'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        mode_t               mode;
        logic [PWM_BITS-1:0] duty;
        logic [PWM_BITS-1:0] ramp;
        logic [PER_BITS-1:0] per;
        logic [PER_BITS-1:0] cnt;
        logic                phase;
        logic                dir_down;
        logic                wr;
        logic [PER_BITS:0]   cnt_inc;
        logic [PER_BITS:0]   eff_per;
        logic                step;

        assign wr      = cfg_we && (cfg_ch == CH_W'(i));
        assign cnt_inc = {1'b0, cnt} + 1'b1;
        // per = 0 behaves as an interval of one tick
        assign eff_per = (per == '0) ? (PER_BITS + 1)'(1) : {1'b0, per};
        assign step    = (cnt_inc >= eff_per);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode     <= MODE_OFF;
                duty     <= '0;
                per      <= '0;
                cnt      <= '0;
                phase    <= 1'b0;
                ramp     <= '0;
                dir_down <= 1'b0;
            end else if (wr) begin
                // a write takes priority over a coincident tick for this channel
                mode     <= mode_t'(cfg_mode);
                duty     <= cfg_duty;
                per      <= cfg_per;
                cnt      <= '0;
                phase    <= 1'b1;
                ramp     <= '0;
                dir_down <= 1'b0;
            end else if (tick) begin
                if (step) begin
                    cnt   <= '0;
                    phase <= ~phase;
                    if (duty == '0) begin
                        ramp     <= '0;
                        dir_down <= 1'b0;
                    end else if (!dir_down && (ramp < duty)) begin
                        ramp <= ramp + 1'b1;
                        if ((ramp + 1'b1) == duty)
                            dir_down <= 1'b1;
                    end else begin
                        ramp <= ramp - 1'b1;
                        if (ramp == PWM_BITS'(1))
                            dir_down <= 1'b0;
                    end
                end else begin
                    cnt <= cnt_inc[PER_BITS-1:0];
                end
            end
        end

        always_comb begin
            led_d[i] = 1'b0;
            case (mode)
                MODE_OFF:     led_d[i] = 1'b0;
                MODE_ON:      led_d[i] = (pwm_cnt < duty);
                MODE_BLINK:   led_d[i] = phase & (pwm_cnt < duty);
                MODE_BREATHE: led_d[i] = (pwm_cnt < ramp);
                default:      led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led <= '0;
        else
            led <= led_d;
    end

endmodule

// File: tb/tb_led_multi_ctl.sv
// Randomized self-checking bench for led_multi_ctl against a tick-count based
// reference model (blink phase and breathe triangle derived arithmetically).
module tb_led_multi_ctl;

    localparam int CH       = 4;
    localparam int TICK_DIV = 4;
    localparam int PWM_BITS = 4;
    localparam int PER_BITS = 4;
    localparam int CH_W     = 3;
    localparam int PWM_N    = 1 << PWM_BITS;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_we = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [1:0]          cfg_mode = '0;
    logic [PWM_BITS-1:0] cfg_duty = '0;
    logic [PER_BITS-1:0] cfg_per = '0;
    logic                tick;
    logic [CH-1:0]       led;

    led_multi_ctl #(
        .CH(CH), .TICK_DIV(TICK_DIV), .PWM_BITS(PWM_BITS),
        .PER_BITS(PER_BITS), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_per(cfg_per),
        .tick(tick), .led(led)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: configuration plus ticks applied since the last write
    int m_mode [CH];
    int m_duty [CH];
    int m_per  [CH];
    int m_ticks[CH];
    int cyc;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_led();
        int v = 0;
        int pwm = cyc % PWM_N;
        for (int i = 0; i < CH; i++) begin
            int eff   = (m_per[i] == 0) ? 1 : m_per[i];
            int steps = m_ticks[i] / eff;
            int ramp  = 0;
            int b     = 0;
            if (m_duty[i] != 0) begin
                int r = steps % (2 * m_duty[i]);
                ramp = (r <= m_duty[i]) ? r : 2 * m_duty[i] - r;
            end
            case (m_mode[i])
                1: b = (pwm < m_duty[i]) ? 1 : 0;
                2: b = ((pwm < m_duty[i]) && (steps % 2 == 0)) ? 1 : 0;
                3: b = (pwm < ramp) ? 1 : 0;
                default: b = 0;
            endcase
            v |= b << i;
        end
        return v;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < CH; i++) begin
            m_mode[i] = 0; m_duty[i] = 0; m_per[i] = 0; m_ticks[i] = 0;
        end
    endtask

    // called just after a posedge (+1); drives inputs, advances one clk, checks
    task automatic cyc_run(input bit we, input int ch, input int mode,
                           input int duty, input int per, input string tag);
        int  e;
        bit  tk;
        cfg_we   = we;
        cfg_ch   = CH_W'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = PWM_BITS'(duty);
        cfg_per  = PER_BITS'(per);
        @(posedge clk);
        e  = exp_led();
        tk = (cyc >= TICK_DIV) && (cyc % TICK_DIV == 0);
        for (int i = 0; i < CH; i++) begin
            if (we && ch == i) begin
                m_mode[i] = mode; m_duty[i] = duty; m_per[i] = per; m_ticks[i] = 0;
            end else if (tk) begin
                m_ticks[i]++;
            end
        end
        cyc++;
        #1;
        chk({tag, " led"}, int'(led), e);
        chk({tag, " tick"}, int'(tick),
            ((cyc >= TICK_DIV) && (cyc % TICK_DIV == 0)) ? 1 : 0);
        cfg_we = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) cyc_run(0, 0, 0, 0, 0, tag);
    endtask

    task automatic count_high(input int bit_i, input string tag, output int cnt);
        cnt = 0;
        for (int k = 0; k < PWM_N; k++) begin
            idle(1, tag);
            cnt += int'(led[bit_i]);
        end
    endtask

    task automatic do_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        chk({tag, " rst led"}, int'(led), 0);
        chk({tag, " rst tick"}, int'(tick), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int cnt;
        model_reset();
        #12;
        chk("init led", int'(led), 0);
        chk("init tick", int'(tick), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle(200, "t1");

        cyc_run(1, 0, 1, 8, 0, "t2w");
        idle(1, "t2");
        count_high(0, "t2", cnt);
        chk("t2 duty8 cnt", cnt, 8);
        cyc_run(1, 0, 1, 0, 0, "t2w");
        idle(1, "t2");
        count_high(0, "t2", cnt);
        chk("t2 duty0 cnt", cnt, 0);
        cyc_run(1, 0, 1, 15, 0, "t2w");
        idle(1, "t2");
        count_high(0, "t2", cnt);
        chk("t2 duty15 cnt", cnt, 15);

        cyc_run(1, 1, 2, 15, 2, "t3w");
        idle(64, "t3");
        cyc_run(1, 1, 2, 15, 0, "t3w");
        idle(40, "t3");

        cyc_run(1, 2, 3, 3, 1, "t4w");
        idle(150, "t4");

        cyc_run(1, 5, 1, 9, 1, "t5w");
        idle(20, "t5");
        while (cyc % TICK_DIV != 0) idle(1, "t5");
        cyc_run(1, 3, 2, 9, 3, "t5w");
        idle(60, "t5");

        idle(7, "t6");
        do_reset("t6");
        idle(40, "t6");

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0)
                cyc_run(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rnd");
            else
                idle(1, "rnd");
            if (n == 2500) do_reset("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
